// File: rtl/lock_code_sender.sv
// Sends a packed BCD code to a digit lock as load-strobed digits plus a confirm pulse and
// reports whether the lock opened. Define LOCK_SENDER_RETRY_EN to enable retries on timeout.
module lock_code_sender #(
    parameter int NUM_DIGITS = 4,
    parameter int GAP_CYCLES = 3,
    parameter int TIMEOUT    = 16,
    parameter int MAX_RETRY  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] code,
    input  logic                    unlocked_in,
    output logic [3:0]              digit_out,
    output logic                    load_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    bad_code
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (NUM_DIGITS < 1 || GAP_CYCLES < 0 || GAP_CYCLES > 255 || TIMEOUT < 1 ||
        TIMEOUT > 65535 || MAX_RETRY < 0) begin : g_bad_param
        $error("lock_code_sender: parameter out of range");
    end

    typedef enum logic [2:0] {
        StIdle, StSend, StGap, StConfirm, StWait, StDone
`ifdef LOCK_SENDER_RETRY_EN
        , StFlush
`endif
    } state_e;

    state_e                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] code_q, code_d, sel_code;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    last_q, last_d;
    logic [7:0]              gap_q, gap_d;
    logic [15:0]             wait_q, wait_d;
    logic [3:0]              digit_q, digit_d;
    logic                    pass_q, pass_d;
    logic                    bad_q, bad_d;
    logic                    nibble_bad;
`ifdef LOCK_SENDER_RETRY_EN
    localparam int RW = ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0]           retry_q, retry_d;
`endif

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        idx_d      = idx_q;
        last_d     = last_q;
        gap_d      = gap_q;
        wait_d     = wait_q;
        digit_d    = digit_q;
        pass_d     = pass_q;
        bad_d      = bad_q;
`ifdef LOCK_SENDER_RETRY_EN
        retry_d    = retry_q;
`endif
        nibble_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (code[4*i +: 4] > 4'd9) nibble_bad = 1'b1;
        end
        // In IDLE the code is not latched yet, so the first digit comes from the input.
        sel_code = (state_q == StIdle) ? code : code_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    code_d  = code;
                    pass_d  = 1'b0;
                    bad_d   = nibble_bad;
                    idx_d   = '0;
                    last_d  = 1'b0;
`ifdef LOCK_SENDER_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = nibble_bad ? StDone : StSend;
                end
            end
            StSend: begin
                if (idx_q == IW'(NUM_DIGITS - 1)) last_d = 1'b1;
                else idx_d = idx_q + 1'b1;
                if (GAP_CYCLES == 0) begin
                    state_d = (idx_q == IW'(NUM_DIGITS - 1)) ? StConfirm : StSend;
                end else begin
                    state_d = StGap;
                    gap_d   = 8'(GAP_CYCLES - 1);
                end
            end
            StGap: begin
                if (gap_q == 8'd0) state_d = last_q ? StConfirm : StSend;
                else gap_d = gap_q - 8'd1;
            end
            StConfirm: begin
                state_d = StWait;
                wait_d  = 16'(TIMEOUT - 1);
            end
            StWait: begin
                if (unlocked_in) begin
                    pass_d  = 1'b1;
                    state_d = StDone;
                end else if (wait_q == 16'd0) begin
`ifdef LOCK_SENDER_RETRY_EN
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StFlush;
                    end else
`endif
                    state_d = StDone;
                end else begin
                    wait_d = wait_q - 16'd1;
                end
            end
`ifdef LOCK_SENDER_RETRY_EN
            StFlush: begin
                idx_d  = '0;
                last_d = 1'b0;
                if (GAP_CYCLES == 0) begin
                    state_d = StSend;
                end else begin
                    state_d = StGap;
                    gap_d   = 8'(GAP_CYCLES - 1);
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d == StSend) digit_d = sel_code[4*int'(idx_d) +: 4];
        else if (state_d == StConfirm) digit_d = 4'd0;
`ifdef LOCK_SENDER_RETRY_EN
        else if (state_d == StFlush) digit_d = 4'd0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            code_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            gap_q   <= '0;
            wait_q  <= '0;
            digit_q <= '0;
            pass_q  <= 1'b0;
            bad_q   <= 1'b0;
`ifdef LOCK_SENDER_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            wait_q  <= wait_d;
            digit_q <= digit_d;
            pass_q  <= pass_d;
            bad_q   <= bad_d;
`ifdef LOCK_SENDER_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    always_comb begin
        load_out = (state_q == StSend) || (state_q == StConfirm);
`ifdef LOCK_SENDER_RETRY_EN
        load_out = load_out || (state_q == StFlush);
`endif
        busy      = (state_q != StIdle) && (state_q != StDone);
        done      = (state_q == StDone);
        digit_out = digit_q;
        pass      = pass_q;
        bad_code  = bad_q;
    end
endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender: pass, timeout, bad code, ignored start, async reset and,
// when LOCK_SENDER_RETRY_EN is defined, the retry sequence.
module tb_lock_code_sender;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] code = 16'h0000;
    logic        unlocked_in = 1'b0;
    logic [3:0]  digit_out;
    logic        load_out, busy, done, pass, bad_code;

    lock_code_sender #(
        .NUM_DIGITS(4),
        .GAP_CYCLES(3),
        .TIMEOUT   (16),
        .MAX_RETRY (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .code       (code),
        .unlocked_in(unlocked_in),
        .digit_out  (digit_out),
        .load_out   (load_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .bad_code   (bad_code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int npulse, ndone, done_cyc, unlock_at;
    logic pass_at_done, bad_at_done;
    logic [3:0] pdig[$];
    int pcyc[$];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pc(input int i);
        return (i < pcyc.size()) ? pcyc[i] - t0 : -1000;
    endfunction

    function automatic int pd(input int i);
        return (i < pdig.size()) ? int'(pdig[i]) : -1;
    endfunction

    // Samples at the falling edge; also plays the receiver, raising unlocked_in after pulse N.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (load_out) begin
            pdig.push_back(digit_out);
            pcyc.push_back(cyc);
            npulse++;
            if (unlock_at != 0 && npulse == unlock_at) unlocked_in = 1'b1;
        end
        if (done) begin
            ndone++;
            done_cyc     = cyc;
            pass_at_done = pass;
            bad_at_done  = bad_code;
        end
    endtask

    task automatic clear_log(input int unlock_pulse);
        pdig.delete();
        pcyc.delete();
        npulse       = 0;
        ndone        = 0;
        done_cyc     = -1;
        pass_at_done = 1'b0;
        bad_at_done  = 1'b0;
        unlock_at    = unlock_pulse;
        unlocked_in  = 1'b0;
    endtask

    // Raises start so the next rising edge (edge T) samples it; cycle T+k is seen at cyc==t0+k.
    task automatic launch(input logic [15:0] c);
        t0    = cyc;
        code  = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget && ndone == 0; i++) tick();
        check("done_seen", ndone, 1);
        tick();
        unlocked_in = 1'b0;
    endtask

    initial begin
        clear_log(0);
        #12;
        check("rst_digit", int'(digit_out), 0);
        check("rst_load", int'(load_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_bad", int'(bad_code), 0);
        tick();
        reset = 1'b0;
        tick();

        // Pass path: digits 4,3,2,1 then confirm 0, unlocked one cycle after confirm.
        clear_log(5);
        launch(16'h1234);
        check("t1_busy_t1", int'(busy), 1);
        run_to_done(60);
        check("t1_npulse", npulse, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t1_dig%0d", i), pd(i), (i == 4) ? 0 : 4 - i);
            check($sformatf("t1_cyc%0d", i), pc(i), 1 + 4 * i);
        end
        check("t1_done_cyc", done_cyc - t0, 19);
        check("t1_pass", int'(pass_at_done), 1);
        check("t1_busy_after", int'(busy), 0);
        tick();
        check("t1_pass_held", int'(pass), 1);

        // Timeout: no unlock ever.
        clear_log(0);
        launch(16'h1111);
        run_to_done(200);
`ifdef LOCK_SENDER_RETRY_EN
        check("t2_npulse", npulse, 17);
`else
        check("t2_npulse", npulse, 5);
        check("t2_dig0", pd(0), 1);
`endif
        check("t2_last_dig", pd(npulse - 1), 0);
        check("t2_done_after_confirm", done_cyc - t0 - pc(npulse - 1), 17);
        check("t2_pass", int'(pass_at_done), 0);
        check("t2_ndone", ndone, 1);

        // Bad code: rejected immediately.
        clear_log(0);
        launch(16'h12A4);
        run_to_done(10);
        check("t3_done_cyc", done_cyc - t0, 1);
        check("t3_bad", int'(bad_at_done), 1);
        check("t3_pass", int'(pass_at_done), 0);
        check("t3_npulse", npulse, 0);
        check("t3_bad_held", int'(bad_code), 1);

        // Starts while busy with a different code are ignored.
        clear_log(5);
        launch(16'h5678);
        check("t4_bad_cleared", int'(bad_code), 0);
        for (int i = 0; i < 40 && ndone == 0; i++) begin
            start = (cyc - t0 == 2) || (cyc - t0 == 9);
            code  = 16'h9999;
            tick();
        end
        start = 1'b0;
        check("t4_done_seen", ndone, 1);
        tick();
        unlocked_in = 1'b0;
        check("t4_npulse", npulse, 5);
        check("t4_dig0", pd(0), 8);
        check("t4_dig1", pd(1), 7);
        check("t4_dig3", pd(3), 5);
        check("t4_done_cyc", done_cyc - t0, 19);
        check("t4_pass", int'(pass_at_done), 1);

        // Async reset between pulses 2 and 3.
        clear_log(0);
        launch(16'h1234);
        for (int i = 0; i < 20 && npulse < 2; i++) tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("t5_digit", int'(digit_out), 0);
        check("t5_load", int'(load_out), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_done", int'(done), 0);
        check("t5_pass", int'(pass), 0);
        check("t5_bad", int'(bad_code), 0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("t5_no_more_pulses", npulse, 2);
        check("t5_no_done", ndone, 0);
        clear_log(5);
        launch(16'h1234);
        run_to_done(60);
        check("t5_restart_dig0", pd(0), 4);
        check("t5_restart_cyc0", pc(0), 1);
        check("t5_restart_pass", int'(pass_at_done), 1);

`ifdef LOCK_SENDER_RETRY_EN
        // Retry: unlock only in the third attempt's WAIT.
        clear_log(17);
        launch(16'h2468);
        run_to_done(300);
        check("t6_npulse", npulse, 17);
        check("t6_flush1_dig", pd(5), 0);
        check("t6_flush1_cyc", pc(5), 34);
        check("t6_retry_dig0", pd(6), 8);
        check("t6_retry_cyc0", pc(6), 38);
        check("t6_flush2_dig", pd(11), 0);
        check("t6_done_cyc", done_cyc - t0, 93);
        check("t6_ndone", ndone, 1);
        check("t6_pass", int'(pass_at_done), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
